// File: rtl/frame_deframer.sv
// Receive-side deframer: hunts for the FAS, confirms alignment over a second frame,
// then flywheels row/column tracking, strips overhead and recovers the ARQ-enable flag.
module frame_deframer #(
  parameter int ROW_LEN    = 1041,
  parameter int NUM_ROWS   = 4,
  parameter int PYLD_START = 16,
  parameter int PYLD_END   = 1039,
  parameter int LOF_THRESH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_line_data,
  input  logic        i_line_data_valid,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_arq_en,
  output logic        o_in_frame,
  output logic        o_frame_start,
  output logic        o_fas_err
);

  localparam int              BAD_W     = $clog2(LOF_THRESH + 1);
  localparam logic [10:0]     COL_LAST  = 11'(ROW_LEN - 1);
  localparam logic [10:0]     COL_PS    = 11'(PYLD_START);
  localparam logic [10:0]     COL_PE    = 11'(PYLD_END);
  localparam logic [10:0]     COL_CHECK = 11'd5;
  localparam logic [10:0]     COL_ARQ   = 11'd6;
  localparam logic [1:0]      ROW_LAST  = 2'(NUM_ROWS - 1);
  localparam logic [BAD_W-1:0] BAD_LIMIT = BAD_W'(LOF_THRESH - 1);
  localparam logic [47:0]     FAS       = 48'hF6F6F6282828;

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

  state_t           state, state_next;
  logic [39:0]      sr;
  logic [1:0]       row, row_next;
  logic [10:0]      col, col_next;
  logic [BAD_W-1:0] bad_cnt, bad_next;
  logic             frame_start_next, fas_err_next;
  logic             fas_match, at_check, in_pyld;

  assign fas_match = ({sr, i_line_data} == FAS);
  assign at_check  = (row == 2'd0) && (col == COL_CHECK);
  assign in_pyld   = (col >= COL_PS) && (col <= COL_PE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= HUNT;
      sr      <= '0;
      row     <= '0;
      col     <= '0;
      bad_cnt <= '0;
    end else begin
      state   <= state_next;
      row     <= row_next;
      col     <= col_next;
      bad_cnt <= bad_next;
      if (i_line_data_valid)
        sr <= {sr[31:0], i_line_data};
    end
  end

  // A HUNT match is the byte at (0,5), so the next valid byte is loaded as (0,6).
  always_comb begin
    state_next       = state;
    row_next         = row;
    col_next         = col;
    bad_next         = bad_cnt;
    frame_start_next = 1'b0;
    fas_err_next     = 1'b0;
    if (i_line_data_valid) begin
      if (state != HUNT) begin
        if (col == COL_LAST) begin
          col_next = '0;
          row_next = (row == ROW_LAST) ? 2'd0 : row + 2'd1;
        end else begin
          col_next = col + 11'd1;
        end
      end
      case (state)
        HUNT: begin
          if (fas_match) begin
            state_next       = PRESYNC;
            row_next         = 2'd0;
            col_next         = COL_ARQ;
            frame_start_next = 1'b1;
          end
        end
        PRESYNC: begin
          if (at_check) begin
            if (fas_match) begin
              state_next       = SYNC;
              frame_start_next = 1'b1;
            end else begin
              state_next   = HUNT;
              fas_err_next = 1'b1;
            end
          end
        end
        SYNC: begin
          if (at_check) begin
            if (fas_match) begin
              bad_next         = '0;
              frame_start_next = 1'b1;
            end else begin
              fas_err_next = 1'b1;
              if (bad_cnt == BAD_LIMIT) begin
                state_next = HUNT;
                bad_next   = '0;
              end else begin
                bad_next = bad_cnt + BAD_W'(1);
              end
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Payload and ARQ decisions use the pre-update state and position of the input byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
      o_row_cnt         <= '0;
      o_col_cnt         <= '0;
      o_arq_en          <= 1'b0;
      o_in_frame        <= 1'b0;
      o_frame_start     <= 1'b0;
      o_fas_err         <= 1'b0;
    end else begin
      o_frame_start     <= frame_start_next;
      o_fas_err         <= fas_err_next;
      o_in_frame        <= (state_next == SYNC);
      o_pyld_data_valid <= 1'b0;
      if (i_line_data_valid && (state == SYNC) && in_pyld) begin
        o_pyld_data       <= i_line_data;
        o_pyld_data_valid <= 1'b1;
        o_row_cnt         <= row;
        o_col_cnt         <= col;
      end
      if (i_line_data_valid && (state == SYNC) && (row == 2'd0) && (col == COL_ARQ)) begin
        if (i_line_data == 8'hFF)
          o_arq_en <= 1'b1;
        else if (i_line_data == 8'h00)
          o_arq_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_deframer.sv
// Scoreboard bench for frame_deframer: directed frames push expected payload into a
// queue, and an independent monitor pops and compares whenever payload is presented.
module tb_frame_deframer;

  localparam int ROW_LEN = 1041;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_line_data;
  logic        i_line_data_valid;
  logic [7:0]  o_pyld_data;
  logic        o_pyld_data_valid;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_arq_en;
  logic        o_in_frame;
  logic        o_frame_start;
  logic        o_fas_err;

  typedef logic [20:0] exp_t;
  exp_t exp_q[$];

  int checks  = 0;
  int errors  = 0;
  int fs_seen = 0;
  int fe_seen = 0;

  frame_deframer dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_line_data       (i_line_data),
    .i_line_data_valid (i_line_data_valid),
    .o_pyld_data       (o_pyld_data),
    .o_pyld_data_valid (o_pyld_data_valid),
    .o_row_cnt         (o_row_cnt),
    .o_col_cnt         (o_col_cnt),
    .o_arq_en          (o_arq_en),
    .o_in_frame        (o_in_frame),
    .o_frame_start     (o_frame_start),
    .o_fas_err         (o_fas_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: counts status pulses and scores every presented payload byte.
  always @(negedge i_clk) begin
    if (o_frame_start) fs_seen++;
    if (o_fas_err) fe_seen++;
    if (!i_rst && o_pyld_data_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pyld_unexpected: got row=%0d col=%0d data=%02h, expected no payload",
                 o_row_cnt, o_col_cnt, o_pyld_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pyld_row_col_data", {11'd0, o_row_cnt, o_col_cnt, o_pyld_data}, {11'd0, e});
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] frame_byte(input int fr, input int r, input int c,
                                            input bit fas_ok, input logic [7:0] arq,
                                            input int false_row);
    if (r == 0 && c <= 2) return (!fas_ok && c == 2) ? 8'h00 : 8'hF6;
    if (r == 0 && c <= 5) return 8'h28;
    if (r == 0 && c == 6) return arq;
    if (r == false_row && c >= 100 && c <= 102) return 8'hF6;
    if (r == false_row && c >= 103 && c <= 105) return 8'h28;
    if (c < 16 || c == ROW_LEN - 1) return 8'hC3;
    return 8'(c + r * 64 + fr * 5);
  endfunction

  task automatic applyStimulus(input logic [7:0] data, input int r, input int c,
                               input bit exp_pyld, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      @(negedge i_clk);
      i_line_data_valid = 1'b0;
      i_line_data       = 8'hF6;
    end
    @(negedge i_clk);
    i_line_data       = data;
    i_line_data_valid = 1'b1;
    if (exp_pyld) exp_q.push_back({2'(r), 11'(c), data});
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_pyld_valid"}, o_pyld_data_valid, 0);
    checkOutput({tag, "_pyld_data"}, o_pyld_data, 0);
    checkOutput({tag, "_row_cnt"}, o_row_cnt, 0);
    checkOutput({tag, "_col_cnt"}, o_col_cnt, 0);
    checkOutput({tag, "_arq_en"}, o_arq_en, 0);
    checkOutput({tag, "_in_frame"}, o_in_frame, 0);
    checkOutput({tag, "_frame_start"}, o_frame_start, 0);
    checkOutput({tag, "_fas_err"}, o_fas_err, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_line_data_valid = 1'b0;
    checkOutput("pre_reset_in_frame", o_in_frame, 1);
    checkOutput("pre_reset_arq_en", o_arq_en, 1);
    #1 i_rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic send_frame(input int fr, input bit fas_ok, input logic [7:0] arq,
                            input bit pyld, input bit gaps, input int false_row,
                            input int rst_row, input int rst_col, input int last_row);
    for (int r = 0; r <= last_row; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        if (r == rst_row && c == rst_col) begin
          do_reset();
          pyld = 1'b0;
        end
        applyStimulus(frame_byte(fr, r, c, fas_ok, arq, false_row), r, c,
                      pyld && c >= 16 && c <= 1039, gaps);
      end
    end
  endtask

  task automatic frame_check(input string tag, input int exp_fs, input int exp_fe,
                             input logic exp_in, input logic exp_arq);
    @(negedge i_clk);
    i_line_data_valid = 1'b0;
    @(negedge i_clk);
    checkOutput({tag, "_frame_start_count"}, fs_seen, exp_fs);
    checkOutput({tag, "_fas_err_count"}, fe_seen, exp_fe);
    checkOutput({tag, "_in_frame"}, o_in_frame, exp_in);
    checkOutput({tag, "_arq_en"}, o_arq_en, exp_arq);
  endtask

  initial begin
    i_rst             = 1'b1;
    i_line_data       = 8'h00;
    i_line_data_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;

    for (int i = 0; i < 37; i++) applyStimulus(8'(i * 7 + 1), 0, 0, 1'b0, 1'b0);

    // Acquisition: first FAS enters PRESYNC, second confirms; ARQ only honoured in SYNC.
    send_frame(1,  1'b1, 8'hFF, 1'b0, 1'b0, -1, -1, -1, 3); frame_check("f1",  1, 0, 1'b0, 1'b0);
    send_frame(2,  1'b1, 8'hFF, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f2",  2, 0, 1'b1, 1'b1);
    send_frame(3,  1'b1, 8'h00, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f3",  3, 0, 1'b1, 1'b0);
    // Three bad FAS checks flywheel through, then a good one clears the count.
    send_frame(4,  1'b0, 8'h5A, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f4",  3, 1, 1'b1, 1'b0);
    send_frame(5,  1'b0, 8'hFF, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f5",  3, 2, 1'b1, 1'b1);
    send_frame(6,  1'b0, 8'h00, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f6",  3, 3, 1'b1, 1'b0);
    send_frame(7,  1'b1, 8'h5A, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f7",  4, 3, 1'b1, 1'b0);
    // Four bad checks: loss of frame on the fourth; a false FAS in its payload is then hunted.
    send_frame(8,  1'b0, 8'h00, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f8",  4, 4, 1'b1, 1'b0);
    send_frame(9,  1'b0, 8'h00, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f9",  4, 5, 1'b1, 1'b0);
    send_frame(10, 1'b0, 8'hFF, 1'b1, 1'b0, -1, -1, -1, 3); frame_check("f10", 4, 6, 1'b1, 1'b1);
    send_frame(11, 1'b0, 8'h00, 1'b0, 1'b0,  1, -1, -1, 3); frame_check("f11", 5, 7, 1'b0, 1'b1);
    send_frame(12, 1'b1, 8'h00, 1'b0, 1'b0, -1, -1, -1, 3); frame_check("f12", 5, 8, 1'b0, 1'b1);
    send_frame(13, 1'b1, 8'h00, 1'b0, 1'b0, -1, -1, -1, 3); frame_check("f13", 6, 8, 1'b0, 1'b1);
    // Gapped input into SYNC, then an async reset mid row 2 forces full re-acquisition.
    send_frame(14, 1'b1, 8'h5A, 1'b1, 1'b1, -1, 2, 500, 3); frame_check("f14", 7, 8, 1'b0, 1'b0);
    send_frame(15, 1'b1, 8'hFF, 1'b0, 1'b0, -1, -1, -1, 3); frame_check("f15", 8, 8, 1'b0, 1'b0);
    send_frame(16, 1'b1, 8'hFF, 1'b1, 1'b0, -1, -1, -1, 1); frame_check("f16", 9, 8, 1'b1, 1'b1);

    repeat (3) @(negedge i_clk);
    checkOutput("scoreboard_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_deframer.md
Name: frame_deframer

Overview:
- Receive-side counterpart of the sender framer. Takes the byte-aligned line stream and locates frame alignment using the FAS (0xF6 x3, 0x28 x3 at row 0, cols 0-5). Tracks row and column, and strips overhead (cols 0-15 of every row, col 1040 of every row). Delivers payload bytes to the client side and recovers the ARQ-enable flag from row 0, col 6.

Parameters:
- ROW_LEN, 1041, columns per row (0..ROW_LEN-1)
- NUM_ROWS, 4, rows per frame
- PYLD_START, 16, first payload column of each row
- PYLD_END, 1039, last payload column of each row
- LOF_THRESH, 4, consecutive bad FAS checks in SYNC that cause loss of frame

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_line_data  in  8  received line byte
- i_line_data_valid  in  1  i_line_data qualifier; counters advance only on valid bytes
- o_pyld_data  out  8  extracted payload byte
- o_pyld_data_valid  out  1  payload qualifier
- o_row_cnt  out  2  row of the byte currently on o_pyld_data
- o_col_cnt  out  11  column of the byte currently on o_pyld_data
- o_arq_en  out  1  recovered ARQ-enable flag
- o_in_frame  out  1  high while in SYNC
- o_frame_start  out  1  one-cycle pulse on each valid FAS match
- o_fas_err  out  1  one-cycle pulse on each failed FAS check in PRESYNC or SYNC

Behaviour:
- Reset: async on i_rst high. All outputs 0; state HUNT; counters 0; shift register 0; bad-FAS count 0.
- Shift register: holds the last 5 valid bytes.
- Window: window = {sr[4:0], i_line_data}, compared against F6 F6 F6 28 28 28, oldest byte first.
- Cycle gating: all state, counter and shift updates occur only on cycles with i_line_data_valid=1. Invalid cycles hold all state, and o_pyld_data_valid=0 on the next cycle.
- Position counter: (row, col) is the position of the current input byte.
  - col increments 0..ROW_LEN-1, then wraps to 0 and row increments.
  - row wraps NUM_ROWS-1 -> 0.
  - The counter runs freely in PRESYNC and SYNC.
- HUNT state:
  - Checks the window on every valid byte.
  - On a match: go to PRESYNC, load the position so the next valid byte is (row 0, col 6), and pulse o_frame_start.
- FAS check point: a valid byte at (row 0, col 5) while in PRESYNC or SYNC.
- PRESYNC state:
  - At the check point, a match goes to SYNC and pulses o_frame_start.
  - A mismatch pulses o_fas_err and goes to HUNT; the counter is ignored in HUNT.
- SYNC state:
  - At the check point, a match clears the bad count and pulses o_frame_start.
  - A mismatch pulses o_fas_err and increments the bad count.
  - When the bad count reaches LOF_THRESH: go to HUNT, clear the bad count, o_in_frame=0.
  - Below the threshold, stay in SYNC and keep the counter free-running (flywheel).
- o_in_frame: registered; equals 1 exactly when the state is SYNC; updates one cycle after the transition.
- Payload path (1-cycle latency, registered):
  - Applies when in SYNC (including a SYNC cycle whose check failed but is below threshold) and the valid input byte has PYLD_START <= col <= PYLD_END.
  - Next cycle: o_pyld_data = byte, o_pyld_data_valid=1, o_row_cnt/o_col_cnt = its position.
  - Otherwise o_pyld_data_valid=0, and o_pyld_data holds its previous value.
  - No payload output in HUNT or PRESYNC, even though the counter runs in PRESYNC.
- ARQ recovery: applies only in SYNC, on the valid byte at (row 0, col 6).
  - 0xFF sets o_arq_en=1.
  - 0x00 sets o_arq_en=0.
  - Any other value leaves o_arq_en unchanged.
  - The flag retains its value through HUNT/PRESYNC and is cleared only by reset.
- Overhead checking: other overhead bytes (rows 1-3 cols 0-15, row 0 cols 7-15, col 1040) are discarded and not checked.
- Width rules:
  - col is 11-bit and compares against ROW_LEN-1 = 1040; it never reaches 2047.
  - row is 2-bit.
  - The bad count is sized to hold LOF_THRESH.
- Simultaneous events: the FAS check and the payload decision use the same pre-update state. The column-5 check never coincides with payload, since col 5 is not a payload column.
- Reset mid-frame: immediate return to HUNT with outputs 0. The first payload appears only after two good FAS matches (HUNT -> PRESYNC -> SYNC).

Test Plan:
- Continuous valid stream: 37 garbage bytes, then 3 well-formed frames with payload byte = col[7:0] -> o_in_frame rises after the 2nd FAS. Payload appears from the 2nd frame on: 1024 bytes per row, o_col_cnt 16..1039, o_row_cnt 0..3, and no bytes from cols 0-15 or 1040.
- Row 0 col 6 = 0xFF in frame 2, then 0x00 in frame 4, then 0x5A in frame 5 -> o_arq_en goes 1 after frame 2, 0 after frame 4, and stays 0 after frame 5.
- In SYNC, corrupt the FAS of 3 consecutive frames, then send a good one -> three o_fas_err pulses, o_in_frame stays 1, payload continues; the good frame clears the count.
- In SYNC, corrupt the FAS of 4 consecutive frames -> the 4th o_fas_err pulse is followed by o_in_frame=0 and no further o_pyld_data_valid until re-acquisition.
- A false FAS pattern in the payload while in HUNT -> PRESYNC is entered; the mismatch one frame later gives o_fas_err and return to HUNT; the true alignment is then acquired.
- i_line_data_valid toggling 1-0-1 randomly across the frame -> output identical to the continuous case apart from gaps. An async i_rst pulse mid-row 2 zeroes all outputs immediately and requires two FAS matches before payload resumes.
